sdram_arbiter: RTL and testbench
================================

# sdram_arbiter

Two-port arbiter that shares one `sdram_controller` instance between two requesters (port 0: CPU/Wishbone bridge; port 1: accelerator/DMA). Each requester runs a hold-until-done handshake. The arbiter selects one request, issues exactly one `in_valid` pulse to the controller while it is not busy, and tracks completion: `out_valid` for reads, a busy rise/fall for writes. It returns completion and read data to the owning port only. A watchdog guarantees every accepted request completes.

## Interface
Parameters:
- `ADDR_W`, 23: user address width, matches controller `user_addr`.
- `DATA_W`, 32: data width.
- `WDOG_CYC`, 1024: cycles from entering ISSUE before forced error completion; minimum 16.

Ports:
- `clk`  in  1  single clock. All logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `p0_valid`, `p1_valid`  in  1  request pending; held high until the matching `done`.
- `p0_rw`, `p1_rw`  in  1  1 = write, 0 = read; stable while valid.
- `p0_addr`, `p1_addr`  in  ADDR_W  request address; stable while valid.
- `p0_wdata`, `p1_wdata`  in  DATA_W  write data; stable while valid.
- `p0_done`, `p1_done`  out  1  one-cycle completion pulse.
- `p0_err`, `p1_err`  out  1  qualifies `done`; 1 = watchdog timeout.
- `p0_rdata`, `p1_rdata`  out  DATA_W  read data; valid with `done`, held until the next `done` on that port.
- `sd_addr`  out  ADDR_W  to controller `user_addr`.
- `sd_rw`  out  1  to controller `rw`.
- `sd_wdata`  out  DATA_W  to controller `data_in`.
- `sd_in_valid`  out  1  to controller `in_valid`.
- `sd_busy`  in  1  from controller `busy`.
- `sd_out_valid`  in  1  from controller `out_valid`.
- `sd_rdata`  in  DATA_W  from controller `data_out`.

## Operation
- State machine: IDLE, ISSUE, WAIT_RD, WAIT_WR_HI, WAIT_WR_LO, RESP.
- IDLE:
  - If any `pX_valid` is high, grant one port.
  - Latch `owner`, `rw`, `addr` and `wdata` into registers, then go to ISSUE.
  - With both ports valid, round-robin: the port not served last wins. The `last` pointer resets to 1, so port 0 wins the first tie.
- ISSUE:
  - `sd_in_valid = ~sd_busy` (combinational). `sd_addr`, `sd_rw` and `sd_wdata` always drive the latched registers.
  - Leave ISSUE in the cycle `sd_in_valid` is 1: read goes to WAIT_RD, write goes to WAIT_WR_HI.
  - While `sd_busy` is high, remain in ISSUE. This covers refresh and the controller re-arming ready.
- WAIT_RD: on `sd_out_valid`, capture `sd_rdata` into the owner's `rdata` register and go to RESP.
- WAIT_WR_HI: on `sd_busy`=1 go to WAIT_WR_LO. WAIT_WR_LO: on `sd_busy`=0 go to RESP.
- RESP: `p<owner>_done`=1 for one cycle, with `err` from the watchdog flag. Update `last` = owner and return to IDLE.
- `sd_out_valid` outside WAIT_RD is ignored. This includes cache-prefetch side effects.
- Watchdog:
  - The counter clears on entry to ISSUE and increments in ISSUE and all WAIT states.
  - At `WDOG_CYC-1`, set `err`, force RESP, and return `rdata` = 32'hDEAD_BEEF for reads.
  - If `sd_out_valid` arrives in the same cycle as the timeout, normal completion wins.
- A requester dropping `valid` before `done` is illegal. The latched copy is used regardless.
- `rst` mid-operation: the FSM goes to IDLE, the in-flight request is discarded with no `done`, and `last`=1. The controller is assumed reset together with the arbiter.

## Timing
- Reset values: `sd_in_valid`=0; `p0_done`, `p1_done`, `p0_err`, `p1_err`=0; `p0_rdata`, `p1_rdata`, `sd_addr`, `sd_wdata`=0; `sd_rw`=0.
- Request sampled in IDLE at cycle T; `sd_in_valid` no earlier than T+1.
- Controller cache-hit read (`out_valid` at T+2): `done` at T+3, so minimum read latency is 3 cycles.
- Write with the controller idle: busy rises at T+2 and falls at T+3 or later; `done` at T+4 at the earliest.
- Back-to-back: a new grant is evaluated in the IDLE cycle following RESP. There is no grant during RESP.
- `sd_in_valid` is high for exactly one cycle per accepted request, and never while `sd_busy`=1.

## Configuration
- `SDRAM_ARB_FIXED_PRIO_EN`:
  - Defined: port 0 always wins a tie, and the `last` pointer is neither kept nor updated.
  - Undefined (default): round-robin as described in Operation.

## Test plan
- Port 0 write addr 0x000010, data 0xA5A5_0001, then port 0 read 0x000010 -> one `sd_in_valid` per request; `p0_done` twice; `p0_rdata`=0xA5A5_0001; `p1_done` never pulses.
- Both ports read on the same cycle after reset, addr 0x100/0x200 -> port 0 served first, then port 1. With `SDRAM_ARB_FIXED_PRIO_EN` defined and port 0 re-requesting immediately, port 0 is served twice first.
- `sd_busy` held high 40 cycles (refresh) while port 1 waits -> `sd_in_valid` stays 0; single pulse in the first cycle `sd_busy`=0.
- Model withholds `sd_out_valid` on a read, `WDOG_CYC`=16 -> `done`+`err` 16 cycles after ISSUE entry; `rdata`=0xDEAD_BEEF; next request proceeds normally.
- Stray `sd_out_valid` while in WAIT_WR_LO -> ignored; write `done` occurs only after `sd_busy` falls.
- `rst` asserted in WAIT_RD -> next cycle all outputs are at reset values; no `done` for the aborted request.

Source files
------------

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one sdram_controller between two hold-until-done requesters.
// Optional SDRAM_ARB_FIXED_PRIO_EN makes port 0 win every tie instead of round-robin.
module sdram_arbiter #(
  parameter int ADDR_W   = 23,
  parameter int DATA_W   = 32,
  parameter int WDOG_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_valid,
  input  logic              p0_rw,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_done,
  output logic              p0_err,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_valid,
  input  logic              p1_rw,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_done,
  output logic              p1_err,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] sd_addr,
  output logic              sd_rw,
  output logic [DATA_W-1:0] sd_wdata,
  output logic              sd_in_valid,
  input  logic              sd_busy,
  input  logic              sd_out_valid,
  input  logic [DATA_W-1:0] sd_rdata
);

  localparam int                CNT_W     = $clog2(WDOG_CYC) + 1;
  localparam logic [CNT_W-1:0]  WDOG_LAST = CNT_W'(WDOG_CYC - 1);
  localparam logic [DATA_W-1:0] ERR_DATA  = DATA_W'(32'hDEAD_BEEF);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    WAIT_WR_HI,
    WAIT_WR_LO,
    RESP
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  wdog_q, wdog_d;
  logic              p0_done_q, p0_done_d;
  logic              p1_done_q, p1_done_d;
  logic              p0_err_q, p0_err_d;
  logic              p1_err_q, p1_err_d;
  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;

  logic              grant_port;
  logic              timeout;
  logic              go_resp;
  logic              go_err;
  logic              rdata_load;
  logic [DATA_W-1:0] rdata_val;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  always_comb grant_port = ~p0_valid;
`else
  logic last_q, last_d;

  // On a tie the port that was not served most recently wins.
  always_comb begin
    if (p0_valid && p1_valid) grant_port = ~last_q;
    else                      grant_port = ~p0_valid;
  end
`endif

  assign timeout = (wdog_q == WDOG_LAST);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wdog_d      = wdog_q;
    p0_done_d   = 1'b0;
    p1_done_d   = 1'b0;
    p0_err_d    = 1'b0;
    p1_err_d    = 1'b0;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
    go_resp     = 1'b0;
    go_err      = 1'b0;
    rdata_load  = 1'b0;
    rdata_val   = sd_rdata;
    sd_in_valid = 1'b0;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
    last_d      = last_q;
`endif

    if (state_q != IDLE && state_q != RESP) wdog_d = wdog_q + CNT_W'(1);

    unique case (state_q)
      IDLE: begin
        if (p0_valid || p1_valid) begin
          owner_d = grant_port;
          rw_d    = grant_port ? p1_rw    : p0_rw;
          addr_d  = grant_port ? p1_addr  : p0_addr;
          wdata_d = grant_port ? p1_wdata : p0_wdata;
          wdog_d  = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        sd_in_valid = ~sd_busy;
        if (!sd_busy) begin
          state_d = rw_q ? WAIT_WR_HI : WAIT_RD;
        end else if (timeout) begin
          go_resp = 1'b1;
          go_err  = 1'b1;
        end
      end
      WAIT_RD: begin
        // A real completion arriving with the timeout beats the error path.
        if (sd_out_valid) begin
          go_resp    = 1'b1;
          rdata_load = 1'b1;
        end else if (timeout) begin
          go_resp = 1'b1;
          go_err  = 1'b1;
        end
      end
      WAIT_WR_HI: begin
        if (sd_busy) begin
          state_d = WAIT_WR_LO;
        end else if (timeout) begin
          go_resp = 1'b1;
          go_err  = 1'b1;
        end
      end
      WAIT_WR_LO: begin
        if (!sd_busy) begin
          go_resp = 1'b1;
        end else if (timeout) begin
          go_resp = 1'b1;
          go_err  = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
        last_d  = owner_q;
`endif
      end
      default: state_d = IDLE;
    endcase

    if (go_err && !rw_q) begin
      rdata_load = 1'b1;
      rdata_val  = ERR_DATA;
    end

    // Completion flags are registered so they line up with the RESP cycle.
    if (go_resp) begin
      state_d = RESP;
      if (owner_q) begin
        p1_done_d = 1'b1;
        p1_err_d  = go_err;
        if (rdata_load) p1_rdata_d = rdata_val;
      end else begin
        p0_done_d = 1'b1;
        p0_err_d  = go_err;
        if (rdata_load) p0_rdata_d = rdata_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wdog_q     <= '0;
      p0_done_q  <= 1'b0;
      p1_done_q  <= 1'b0;
      p0_err_q   <= 1'b0;
      p1_err_q   <= 1'b0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
      last_q     <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wdog_q     <= wdog_d;
      p0_done_q  <= p0_done_d;
      p1_done_q  <= p1_done_d;
      p0_err_q   <= p0_err_d;
      p1_err_q   <= p1_err_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
      last_q     <= last_d;
`endif
    end
  end

  assign sd_addr  = addr_q;
  assign sd_rw    = rw_q;
  assign sd_wdata = wdata_q;
  assign p0_done  = p0_done_q;
  assign p1_done  = p1_done_q;
  assign p0_err   = p0_err_q;
  assign p1_err   = p1_err_q;
  assign p0_rdata = p0_rdata_q;
  assign p1_rdata = p1_rdata_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed and randomized checks of sdram_arbiter against a
// simple controller model and a memory/ordering reference model.
module tb_sdram_arbiter;

  localparam int WDOG = 48;

  logic        clk;
  logic        rst;
  logic        p0_valid, p1_valid;
  logic        p0_rw, p1_rw;
  logic [22:0] p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic        p0_done, p1_done, p0_err, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [22:0] sd_addr;
  logic        sd_rw, sd_in_valid;
  logic [31:0] sd_wdata;
  logic        sd_busy, sd_out_valid;
  logic [31:0] sd_rdata;

  sdram_arbiter #(.ADDR_W(23), .DATA_W(32), .WDOG_CYC(WDOG)) dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_rw(p0_rw), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_done(p0_done), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_valid(p1_valid), .p1_rw(p1_rw), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_done(p1_done), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .sd_addr(sd_addr), .sd_rw(sd_rw), .sd_wdata(sd_wdata), .sd_in_valid(sd_in_valid),
    .sd_busy(sd_busy), .sd_out_valid(sd_out_valid), .sd_rdata(sd_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Controller model knobs and state
  bit        force_busy = 0, withhold = 0, stray_ov = 0, rand_ref = 0;
  int        rd_lat_fix = 0, wr_lat_fix = 1;
  logic [31:0] stray_data = '0;
  int        wr_left = 0, rd_left = 0, ref_left = 0;
  logic      model_ov = 1'b0;
  logic [31:0] model_rdata = '0, rd_hold = '0;
  bit [31:0] mem_dev [1024];

  // Reference model
  bit [31:0]   ref_mem [1024];
  bit          pend [2];
  logic        rw_r [2];
  logic [22:0] addr_r [2];
  logic [31:0] wd_r [2];
  bit          exp_err [2];
  int          exp_done_cyc [2] = '{-1, -1};
  int          done_cnt [2];
  int          done_q [$];
  int          issue_cnt = 0;
  bit          rr_arm = 0;
  int          rr_last = 0, rr_expect = -1;

  assign sd_busy      = force_busy | (wr_left != 0) | (rd_left != 0) | (ref_left != 0);
  assign sd_out_valid = model_ov | stray_ov;
  assign sd_rdata     = stray_ov ? stray_data : model_rdata;

  // Controller model: accepts one command when idle, reports reads via out_valid
  always @(posedge clk) begin
    int lat;
    if (rst) begin
      wr_left <= 0; rd_left <= 0; ref_left <= 0; model_ov <= 1'b0;
    end else begin
      model_ov <= 1'b0;
      if (wr_left != 0) wr_left <= wr_left - 1;
      if (ref_left != 0) ref_left <= ref_left - 1;
      if (rd_left != 0) begin
        rd_left <= rd_left - 1;
        if (rd_left == 1) begin model_ov <= 1'b1; model_rdata <= rd_hold; end
      end
      if (sd_in_valid && !sd_busy) begin
        if (sd_rw) begin
          mem_dev[sd_addr[9:0]] <= sd_wdata;
          wr_left <= (wr_lat_fix > 0) ? wr_lat_fix : int'($urandom_range(1, 4));
        end else if (!withhold) begin
          lat = (rd_lat_fix >= 0) ? rd_lat_fix : int'($urandom_range(0, 3));
          if (lat == 0) begin
            model_ov <= 1'b1; model_rdata <= mem_dev[sd_addr[9:0]];
          end else begin
            rd_left <= lat; rd_hold <= mem_dev[sd_addr[9:0]];
          end
        end
      end else if (rand_ref && !sd_busy && $urandom_range(0, 49) == 0) begin
        ref_left <= int'($urandom_range(3, 15));
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic bit issueMatches();
    for (int p = 0; p < 2; p++)
      if (pend[p] && sd_rw === rw_r[p] && sd_addr === addr_r[p] && sd_wdata === wd_r[p]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic serviceDone(input int p, input logic err, input logic [31:0] rdata);
    checkOutput(p ? "p1_done_pending" : "p0_done_pending", 64'(pend[p]), 64'(1));
    if (pend[p]) begin
      checkOutput(p ? "p1_err" : "p0_err", 64'(err), 64'(exp_err[p]));
      if (!rw_r[p])
        checkOutput(p ? "p1_rdata" : "p0_rdata", 64'(rdata),
                    64'(exp_err[p] ? 32'hDEAD_BEEF : ref_mem[addr_r[p][9:0]]));
      else if (!exp_err[p])
        ref_mem[addr_r[p][9:0]] = wd_r[p];
      if (exp_done_cyc[p] >= 0) checkOutput("done_cycle", 64'(cyc), 64'(exp_done_cyc[p]));
      if (rr_expect >= 0) checkOutput("grant_order", 64'(p), 64'(rr_expect));
      done_q.push_back(p);
      done_cnt[p]++;
      pend[p] = 1'b0;
      exp_err[p] = 1'b0;
      exp_done_cyc[p] = -1;
      rr_arm = 1'b1;
      rr_last = p;
      rr_expect = -1;
    end
  endtask

  // Observe outputs mid-cycle; a completion at cycle d fixes who must win the grant taken at d+1
  always @(negedge clk) begin
    if (rst) begin
      rr_arm = 1'b0;
      rr_expect = -1;
    end else begin
      if (rr_arm) begin
        rr_arm = 1'b0;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
        rr_expect = pend[0] ? 0 : (pend[1] ? 1 : -1);
`else
        rr_expect = pend[1-rr_last] ? 1 - rr_last : (pend[rr_last] ? rr_last : -1);
`endif
      end
      if (sd_in_valid) begin
        issue_cnt++;
        checkOutput("in_valid_while_busy", 64'(sd_busy), 64'(0));
        checkOutput("issue_matches_request", 64'(issueMatches()), 64'(1));
      end
      if (p0_done) serviceDone(0, p0_err, p0_rdata);
      if (p1_done) serviceDone(1, p1_err, p1_rdata);
    end
  end

  task automatic drivePorts();
    p0_valid = pend[0]; p0_rw = rw_r[0]; p0_addr = addr_r[0]; p0_wdata = wd_r[0];
    p1_valid = pend[1]; p1_rw = rw_r[1]; p1_addr = addr_r[1]; p1_wdata = wd_r[1];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drivePorts();
  endtask

  task automatic applyStimulus(input int p, input logic rw, input logic [22:0] addr, input logic [31:0] wd);
    pend[p] = 1'b1; rw_r[p] = rw; addr_r[p] = addr; wd_r[p] = wd;
    drivePorts();
  endtask

  task automatic waitDone(input int p, input int maxc);
    int n = 0;
    while (pend[p] && n < maxc) begin tick(); n++; end
    checkOutput(p ? "p1_wait_done" : "p0_wait_done", 64'(pend[p]), 64'(0));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_in_valid"}, 64'(sd_in_valid), 64'(0));
    checkOutput({tag, "_done"}, 64'({p0_done, p1_done, p0_err, p1_err}), 64'(0));
    checkOutput({tag, "_rdata"}, {p0_rdata, p1_rdata}, 64'(0));
    checkOutput({tag, "_sd_bus"}, 64'({sd_rw, sd_addr, sd_wdata}), 64'(0));
  endtask

  initial begin
    int i0, d1, o0;
    rst = 1'b1;
    for (int p = 0; p < 2; p++) begin pend[p] = 0; rw_r[p] = 0; addr_r[p] = '0; wd_r[p] = '0; end
    drivePorts();
    repeat (3) tick();
    checkResetOutputs("reset");
    rst = 1'b0;
    tick();

    // Port 0 write then read-back at minimum latency
    rd_lat_fix = 0; wr_lat_fix = 1;
    i0 = issue_cnt; d1 = done_cnt[1];
    applyStimulus(0, 1'b1, 23'h10, 32'hA5A5_0001);
    exp_done_cyc[0] = cyc + 4;
    waitDone(0, 50);
    applyStimulus(0, 1'b0, 23'h10, $urandom);
    exp_done_cyc[0] = cyc + 3;
    waitDone(0, 50);
    checkOutput("rw_p0_rdata", 64'(p0_rdata), 64'(32'hA5A5_0001));
    checkOutput("rw_issue_count", 64'(issue_cnt - i0), 64'(2));
    checkOutput("rw_p0_done_count", 64'(done_cnt[0]), 64'(2));
    checkOutput("rw_p1_silent", 64'(done_cnt[1] - d1), 64'(0));

    // Refresh: controller busy for 40 cycles while port 1 waits
    rd_lat_fix = 2;
    force_busy = 1'b1;
    i0 = issue_cnt;
    applyStimulus(1, 1'b0, 23'h10, $urandom);
    repeat (40) tick();
    checkOutput("refresh_no_issue", 64'(issue_cnt - i0), 64'(0));
    force_busy = 1'b0;
    @(negedge clk);
    checkOutput("refresh_pulse", 64'(sd_in_valid), 64'(1));
    waitDone(1, 50);
    checkOutput("refresh_issue_count", 64'(issue_cnt - i0), 64'(1));

    // Stray out_valid while the write is waiting for busy to fall
    wr_lat_fix = 6;
    applyStimulus(0, 1'b1, 23'h20, 32'h1234_5678);
    exp_done_cyc[0] = cyc + 9;
    repeat (4) tick();
    stray_data = 32'hBAD0_0BAD; stray_ov = 1'b1;
    tick();
    stray_ov = 1'b0;
    waitDone(0, 50);
    checkOutput("stray_rdata_kept", 64'(p0_rdata), 64'(32'hA5A5_0001));
    wr_lat_fix = 1;

    // Watchdog on a read that never returns, then a normal read
    withhold = 1'b1;
    applyStimulus(1, 1'b0, 23'h30, $urandom);
    exp_err[1] = 1'b1;
    exp_done_cyc[1] = cyc + 1 + WDOG;
    waitDone(1, 200);
    checkOutput("wdog_rdata", 64'(p1_rdata), 64'(32'hDEAD_BEEF));
    withhold = 1'b0;
    applyStimulus(1, 1'b0, 23'h20, $urandom);
    waitDone(1, 50);
    checkOutput("post_wdog_rdata", 64'(p1_rdata), 64'(32'h1234_5678));

    // Reset while waiting for read data: request dropped, no completion
    withhold = 1'b1;
    d1 = done_cnt[0];
    applyStimulus(0, 1'b0, 23'h10, $urandom);
    repeat (3) tick();
    rst = 1'b1;
    pend[0] = 1'b0;
    drivePorts();
    tick();
    checkResetOutputs("abort");
    rst = 1'b0;
    withhold = 1'b0;
    repeat (4) tick();
    checkOutput("abort_no_done", 64'(done_cnt[0] - d1), 64'(0));

    // Tie after reset; port 0 re-requests immediately after its first completion
    o0 = done_q.size();
    applyStimulus(0, 1'b0, 23'h100, $urandom);
    applyStimulus(1, 1'b0, 23'h200, $urandom);
    waitDone(0, 50);
    applyStimulus(0, 1'b0, 23'h110, $urandom);
    waitDone(1, 100);
    waitDone(0, 100);
    if (done_q.size() >= o0 + 3) begin
      checkOutput("tie_first", 64'(done_q[o0]), 64'(0));
`ifdef SDRAM_ARB_FIXED_PRIO_EN
      checkOutput("tie_second", 64'(done_q[o0+1]), 64'(0));
      checkOutput("tie_third", 64'(done_q[o0+2]), 64'(1));
`else
      checkOutput("tie_second", 64'(done_q[o0+1]), 64'(1));
      checkOutput("tie_third", 64'(done_q[o0+2]), 64'(0));
`endif
    end else begin
      checkOutput("tie_count", 64'(done_q.size()), 64'(o0 + 3));
    end

    // Randomized traffic with random controller latency and refresh
    rd_lat_fix = -1; wr_lat_fix = -1; rand_ref = 1'b1;
    for (int i = 0; i < 600; i++) begin
      tick();
      for (int p = 0; p < 2; p++)
        if (!pend[p] && $urandom_range(0, 2) == 0)
          applyStimulus(p, 1'($urandom_range(0, 1)), 23'($urandom_range(0, 31)), $urandom);
    end
    waitDone(0, 300);
    waitDone(1, 300);
    rand_ref = 1'b0;
    checkOutput("random_issue_total", 64'(issue_cnt), 64'(done_cnt[0] + done_cnt[1] + 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
